// File: rtl/conv2d_fold_scheduler.sv
// rtl/conv2d_fold_scheduler.sv - walks pixel -> NF -> SF fold nest, issuing MAC steps and weight rows
module conv2d_fold_scheduler #(
  parameter int PE     = 16,
  parameter int SIMD   = 8,
  parameter int K      = 3,
  parameter int IFM_CH = 32,
  parameter int OFM_CH = 64,
  parameter int PIX_W  = 16,
  localparam int SF    = K * K * IFM_CH / SIMD,
  localparam int NF    = OFM_CH / PE,
  localparam int WA_W  = $clog2(SF * NF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] cfg_num_pix,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             step_valid,
  output logic [WA_W-1:0]  wgt_addr,
  output logic             acc_clear,
  output logic             acc_last,
  output logic             busy,
  output logic             done
);

  localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;

  if ((K * K * IFM_CH) % SIMD != 0) begin : g_bad_simd
    $error("K*K*IFM_CH must be a multiple of SIMD");
  end
  if (OFM_CH % PE != 0) begin : g_bad_pe
    $error("OFM_CH must be a multiple of PE");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [SF_W-1:0]  sf;
  logic [NF_W-1:0]  nf;
  logic [PIX_W-1:0] pix, npix;
  logic             done_q;
  logic             sf_end, nf_end, pix_end, last_step;

  assign sf_end    = (sf == SF_W'(SF - 1));
  assign nf_end    = (nf == NF_W'(NF - 1));
  assign pix_end   = (pix == npix - PIX_W'(1));
  assign last_step = step_valid && sf_end && nf_end && pix_end;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_num_pix != '0) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is forced low while rst is asserted, even before the reset edge lands.
  always_comb begin
    busy       = 1'b0;
    in_ready   = 1'b0;
    step_valid = 1'b0;
    acc_clear  = 1'b0;
    acc_last   = 1'b0;
    wgt_addr   = '0;
    done       = 1'b0;
    if (!rst) begin
      busy       = (state == RUN);
      in_ready   = busy && (!sf_end || out_ready);
      step_valid = in_ready && in_valid;
      acc_clear  = step_valid && (sf == '0);
      acc_last   = step_valid && sf_end;
      wgt_addr   = WA_W'(nf) * WA_W'(SF) + WA_W'(sf);
      done       = done_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sf     <= '0;
      nf     <= '0;
      pix    <= '0;
      npix   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          npix <= cfg_num_pix;
          if (cfg_num_pix == '0) done_q <= 1'b1;
        end
      end else if (step_valid) begin
        if (last_step) begin
          sf     <= '0;
          nf     <= '0;
          pix    <= '0;
          done_q <= 1'b1;
        end else if (sf_end) begin
          sf <= '0;
          if (nf_end) begin
            nf  <= '0;
            pix <= pix + PIX_W'(1);
          end else begin
            nf <= nf + NF_W'(1);
          end
        end else begin
          sf <= sf + SF_W'(1);
        end
      end
    end
  end

endmodule
